// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan display.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Entries are stored with dp off (bit 7 high).
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } phase_e;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low 7-segment pattern.
// The decimal-point input is passed straight through to bit 7.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] pattern;

    assign pattern = HEX_SEG[digit_i];
    assign seg_o   = {dp_i, pattern[6:0]};

endmodule

// File: rtl/rc_cascade_display.sv
// Extends a 4-bit ripple counter to 16 bits by counting its carry pulses,
// then scans the captured value as four hex digits onto a common-anode display.
module rc_cascade_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            q,
    input  logic                  rc,
    input  logic                  hold,
    output logic [15:0]           value,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic                  ovf
);

    logic                  rc_q;
    logic [11:0]           hi_q, hi_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           value_q, value_d;
    logic [SCAN_DIV-1:0]   presc_q, presc_d;
    logic [1:0]            idx_q, idx_d;
    phase_e                phase_q, phase_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;

    logic       rise;
    logic       tick;
    logic [3:0] digit;
    logic       dp;
    logic [7:0] dec_seg;

    // rc_q resets high so a carry already asserted at reset release is not counted.
    assign rise = rc & ~rc_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        if (rise) begin
            hi_d = hi_q + 12'd1;
            if (hi_q == 12'hFFF) begin
                ovf_d = 1'b1;
            end
        end
        value_d = hold ? value_q : {hi_q, q};
    end

    assign tick  = (presc_q == '1);
    assign digit = value_q[{idx_q, 2'b00} +: 4];
    assign dp    = (idx_q == 2'd0) ? ~ovf_q : 1'b1;

    hex7seg u_hex7seg (
        .digit_i (digit),
        .dp_i    (dp),
        .seg_o   (dec_seg)
    );

    // seg tracks the selected digit every cycle so live value changes show at once.
    always_comb begin
        presc_d = presc_q + 1'b1;
        phase_d = phase_q;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = dec_seg;
        case (phase_q)
            SHOW: begin
                if (tick) begin
                    phase_d = BLANK;
                    an_d    = '1;
                    idx_d   = idx_q + 2'd1;
                end
            end
            BLANK: begin
                phase_d = SHOW;
                an_d    = ~(4'b0001 << idx_q);
            end
            default: phase_d = SHOW;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q    <= 1'b1;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            value_q <= '0;
        end else begin
            rc_q    <= rc;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
            value_q <= value_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= 2'd3;
            phase_q <= SHOW;
            an_q    <= '1;
            seg_q   <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_rc_cascade_display.sv
// Self-checking bench for rc_cascade_display with SCAN_DIV = 2: per-cycle
// comparison against an arithmetic reference model plus directed corner cases.
module tb_rc_cascade_display;

    localparam int SCAN_DIV = 2;

    localparam logic [7:0] SEG_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  q     = 4'h0;
    logic        rc    = 1'b1;
    logic        hold  = 1'b0;
    logic [15:0] value;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        ovf;

    rc_cascade_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q),
        .rc    (rc),
        .hold  (hold),
        .value (value),
        .an    (an),
        .seg   (seg),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: carry count, capture register, and the pre-edge snapshot
    // that the registered display outputs are derived from.
    int m_hi, m_value, m_edges, p_value;
    bit m_ovf, m_prev_rc, p_ovf;

    typedef struct {
        logic       hold;
        logic [3:0] q;
        logic [3:0] an;
        logic [7:0] seg;
    } frame_vec_t;

    frame_vec_t fv [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Digit selected once e clock edges have elapsed since reset release.
    function automatic int idx_after(input int e);
        return (e < 4) ? 3 : ((e / 4) - 1) % 4;
    endfunction

    function automatic logic [3:0] exp_an();
        if (m_edges < 4 || (m_edges % 4) == 0) return 4'hF;
        return ~(4'b0001 << idx_after(m_edges));
    endfunction

    function automatic logic [7:0] exp_seg();
        int i;
        logic [7:0] s;
        if (m_edges == 0) return 8'hFF;
        i = idx_after(m_edges - 1);
        s = SEG_TBL[(p_value >> (4 * i)) & 15];
        if (i == 0 && p_ovf) s[7] = 1'b0;
        return s;
    endfunction

    task automatic check_all();
        check("value", {16'h0, value}, m_value);
        check("ovf", {31'h0, ovf}, {31'h0, m_ovf});
        check("an", {28'h0, an}, {28'h0, exp_an()});
        check("seg", {24'h0, seg}, {24'h0, exp_seg()});
    endtask

    task automatic model_edge();
        p_value = m_value;
        p_ovf   = m_ovf;
        if (!hold) m_value = (m_hi << 4) | int'(q);
        if (rc && !m_prev_rc) begin
            if (m_hi == 4095) m_ovf = 1'b1;
            m_hi = (m_hi + 1) % 4096;
        end
        m_prev_rc = rc;
        m_edges++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_value", {16'h0, value}, 32'h0);
        check("rst_an", {28'h0, an}, 32'hF);
        check("rst_seg", {24'h0, seg}, 32'hFF);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        m_hi = 0; m_ovf = 1'b0; m_prev_rc = 1'b1; m_value = 0; m_edges = 0;
        p_value = 0; p_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    task automatic rc_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            q = 4'($urandom); rc = 1'b1; step();
            rc = 1'b0; step();
        end
    endtask

    task automatic wraps(input int n);
        for (int w = 0; w < n; w++) begin
            for (int v = 0; v < 16; v++) begin
                q = 4'(v); rc = (v == 15); step();
            end
        end
    endtask

    initial begin
        fv[0]  = '{1'b1, 4'h4, 4'b1111, 8'hF9};
        fv[1]  = '{1'b1, 4'h4, 4'b1110, 8'h99};
        fv[2]  = '{1'b1, 4'h4, 4'b1110, 8'h99};
        fv[3]  = '{1'b1, 4'h4, 4'b1110, 8'h99};
        fv[4]  = '{1'b1, 4'h4, 4'b1111, 8'h99};
        fv[5]  = '{1'b1, 4'h4, 4'b1101, 8'hB0};
        fv[6]  = '{1'b1, 4'h4, 4'b1101, 8'hB0};
        fv[7]  = '{1'b1, 4'h4, 4'b1101, 8'hB0};
        fv[8]  = '{1'b1, 4'h4, 4'b1111, 8'hB0};
        fv[9]  = '{1'b1, 4'h4, 4'b1011, 8'hA4};
        fv[10] = '{1'b1, 4'h4, 4'b1011, 8'hA4};
        fv[11] = '{1'b1, 4'h4, 4'b1011, 8'hA4};
        fv[12] = '{1'b1, 4'h4, 4'b1111, 8'hA4};
        fv[13] = '{1'b1, 4'h4, 4'b0111, 8'hF9};
        fv[14] = '{1'b1, 4'h4, 4'b0111, 8'hF9};
        fv[15] = '{1'b1, 4'h4, 4'b0111, 8'hF9};

        #2;
        // Reset with rc held high; the held carry must not count after release.
        rc = 1'b1; q = 4'h0;
        do_reset();
        repeat (3) step();
        check("hi_after_reset", {20'h0, value[15:4]}, 32'h0);

        // 16 full counter wraps.
        q = 4'h0; rc = 1'b0; step();
        wraps(16);
        q = 4'h0; rc = 1'b0; step();
        check("value_16_wraps", {16'h0, value}, 32'h0100);
        check("ovf_16_wraps", {31'h0, ovf}, 32'h0);

        // A carry held for 5 cycles counts once.
        q = 4'h1; rc = 1'b0; step();
        rc = 1'b1; repeat (5) step();
        rc = 1'b0; repeat (2) step();
        check("rc_level_once", {20'h0, value[15:4]}, 32'h011);

        // Hold freezes value while carries still advance hi.
        q = 4'h0; rc = 1'b0; step();
        hold = 1'b1;
        wraps(3);
        check("hold_frozen", {16'h0, value}, 32'h0110);
        hold = 1'b0; q = 4'h0; rc = 1'b0; step();
        check("hold_release", {16'h0, value}, 32'h0140);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            q    = 4'($urandom);
            rc   = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 7) == 0);
            step();
        end

        // Scan of value 16'h1234 over one frame.
        rc = 1'b0; hold = 1'b0;
        do_reset();
        step();
        rc_pulses(12'h123);
        q = 4'h4; rc = 1'b0; repeat (2) step();
        check("value_1234", {16'h0, value}, 32'h1234);
        while ((m_edges % 16) != 3) step();
        for (int i = 0; i < 16; i++) begin
            hold = fv[i].hold; q = fv[i].q;
            step();
            check($sformatf("frame_an[%0d]", i), {28'h0, an}, {28'h0, fv[i].an});
            check($sformatf("frame_seg[%0d]", i), {24'h0, seg}, {24'h0, fv[i].seg});
        end
        repeat (3) step();
        check("pre_reset_an", {28'h0, an}, 32'hE);
        do_reset();

        // 4096 carries wrap hi and set the sticky overflow.
        hold = 1'b0; rc = 1'b0; step();
        rc_pulses(4096);
        q = 4'h0; rc = 1'b0; step();
        check("hi_wrapped", {20'h0, value[15:4]}, 32'h0);
        check("ovf_set", {31'h0, ovf}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            step();
            if (exp_an() == 4'b1110)
                check("dp_digit0", {31'h0, seg[7]}, 32'h0);
            else if (exp_an() != 4'b1111)
                check("dp_other", {31'h0, seg[7]}, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc_cascade_display.md
# rc_cascade_display

Downstream consumer of the 4-bit ripple counter (outputs Qa..Qd, Rc). It extends the count to 16 bits by counting Rc carry events into a 12-bit high counter. It captures the combined value and time-multiplexes it as four hex digits onto a common-anode 7-segment display. It sits between the counter and the board display pins, on the same clock as the counter.

## Interface
- SCAN_DIV, 17: prescaler width. One scan tick every 2^SCAN_DIV clocks. Benches use 2.
- clk  in  1  system clock, rising edge; shared with the counter.
- rst_n  in  1  asynchronous, active-low reset.
- q  in  4  counter value {Qd,Qc,Qb,Qa}; Qa is the LSB.
- rc  in  1  counter ripple carry. High while q==4'hF.
- hold  in  1  1 = freeze the displayed/captured value.
- value  out  16  captured count {hi[11:0], q}.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit (value[3:0]).
- seg  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- ovf  out  1  sticky flag: high counter wrapped.

## Operation
- Carry detect:
  - rc_d registers rc; reset value 1, so rc held high through reset is not counted.
  - rise = rc & ~rc_d.
  - A level of rc lasting N ≥ 1 cycles gives exactly one increment.
- High counter hi[11:0]:
  - On rise, hi <= hi + 1, modulo 4096.
  - If hi == 12'hFFF at that increment, ovf <= 1. ovf clears only on reset.
- Capture: when hold == 0, value <= {hi, q} every cycle. When hold == 1, value is retained.
- Scan state: 2-bit digit index idx, plus a phase bit (SHOW / BLANK).
  - prescaler counts 0 .. 2^SCAN_DIV − 1 and wraps; tick = (prescaler == max).
  - SHOW, tick: go to BLANK, an <= 4'b1111, idx <= idx + 1 (wraps 3→0).
  - BLANK: next cycle go to SHOW. an <= ~(1 << idx) and seg <= decode(value[4*idx +: 4]).
  - In SHOW, seg is re-decoded every cycle from the current value digit, so a live update is visible without waiting for a tick.
  - dp (seg[7]) = ~ovf while idx == 0, otherwise 1.
- Hex decode: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E. These are the values of seg with dp off.
- Reset values:
  - value = 0, ovf = 0, hi = 0, rc_d = 1.
  - prescaler = 0, idx = 3, phase = SHOW.
  - an = 4'b1111, seg = 8'hFF.
  - The first tick selects digit 0.
- Reset asserted mid-operation returns every register to its reset value immediately, with no clock needed.
- A rise on the same cycle as hold = 1: hi still increments; only value freezes.

## Timing
- rc rise → hi updated at the next clock edge. value reflects it one edge later (2 edges total).
- With the counter on the same clk: the cycle with q == F is followed by q == 0 in the same cycle that hi has incremented, so value never shows a torn {hi, q}.
- Digit dwell: 2^SCAN_DIV − 1 cycles visible, then 1 cycle blank (anti-ghosting).
- Full scan frame: 4 · 2^SCAN_DIV cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package seg7_pkg:
  - NUM_DIGITS = 4.
  - 16-entry hex-to-segment constant table.
  - Phase enum: SHOW, BLANK.
- Sub-module hex7seg: purely combinational, 4-bit → 8-bit decode using the package table, dp input passed through. It is instantiated once, on the muxed digit.
- The remaining logic (edge detect, hi counter, capture register, prescaler, scan state machine) lives in rc_cascade_display.

## Test plan
All scenarios use SCAN_DIV = 2.
- Reset: rst_n = 0 with rc = 1 → value = 0, an = 1111, seg = FF, ovf = 0. After release with rc still high, hi stays 0.
- 16 full counter wraps (q stepping 0..F, rc high on F) → value = 16'h0100 when q == 0; ovf = 0.
- rc held high for 5 cycles → hi increases by exactly 1.
- 4096 wraps → hi = 000 and ovf = 1. The digit-0 frame shows seg[7] = 0; other digits show seg[7] = 1.
- hold = 1 during 3 wraps → value is unchanged. After hold = 0, value = {old hi + 3, q} within 1 cycle.
- value = 16'h1234, observed over one frame:
  - an steps 1110 / 1101 / 1011 / 0111, with 1111 for one cycle between digits.
  - seg = 99 / B0 / A4 / F9 for digits 0..3 (4, 3, 2, 1).
  - rst_n pulsed mid-frame → an = 1111 in the same cycle.
